// File: rtl/ov_emu_pkg.sv
// Shared definitions for the OV2640-style sensor emulator: FSM states,
// pattern select codes and the RGB565 colour-bar palette.
package ov_emu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_HBLANK,
        S_VFP
    } ov_state_t;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_SOLID   = 2'd3;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov_pattern_gen.sv
// Combinational test-pattern source: pixel coordinates and pattern select
// to one RGB565 pixel.
module ov_pattern_gen
    import ov_emu_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    sel,
    output logic [15:0]   rgb
);

    logic [5:0] x6;
    logic [5:0] y6;
    logic [2:0] bar;

    // Coordinates are resized to the bit fields the patterns use, so narrow
    // geometries still produce well-defined ramp and checker values.
    always_comb begin
        x6  = 6'(x);
        y6  = 6'(y);
        bar = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
        case (sel)
            PAT_BARS:    rgb = bar_colour(bar);
            PAT_RAMP:    rgb = {x6[4:0], y6, x6[4:0] ^ y6[4:0]};
            PAT_CHECKER: rgb = (x6[5] ^ y6[5]) ? 16'hFFFF : 16'h0000;
            default:     rgb = 16'hFFFF;
        endcase
    end

endmodule

// File: rtl/ov_sensor_emulator.sv
// OV2640-style video source: registered PCLK, HREF/VSYNC line and frame
// timing, RGB565 pixels sent high byte first.
module ov_sensor_emulator
    import ov_emu_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int V_FP        = 10,
    parameter int PCLK_DIV    = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       PCLK_OV,
    output logic       HREF_OV,
    output logic       VSYNC_OV,
    output logic [7:0] OV_Data_in,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int MAX_L1     = (VSYNC_LINES > V_BP) ? VSYNC_LINES : V_BP;
    localparam int MAX_LINES  = (MAX_L1 > V_FP) ? MAX_L1 : V_FP;
    localparam int PW         = $clog2(PCLK_DIV);
    localparam int CW         = $clog2(LINE_TICKS);
    localparam int LW         = $clog2(MAX_LINES + 1);
    localparam int XW         = $clog2(H_ACTIVE + 1);
    localparam int YW         = $clog2(V_ACTIVE + 1);

    ov_state_t     state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [LW-1:0] line_idx, line_n, seg_last;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic          odd, odd_n;
    logic [1:0]    sel, sel_n;
    logic          tick, line_end, seg_end, done_n, href_n, vsync_n;
    logic [7:0]    data_n;
    logic [15:0]   rgb;

    assign tick = (ph == PW'(PCLK_DIV - 1));
    assign ph_n = tick ? '0 : ph + PW'(1);

    ov_pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .XW      (XW),
        .YW      (YW)
    ) u_pattern (
        .x  (x_n),
        .y  (y_n),
        .sel(sel_n),
        .rgb(rgb)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        line_n   = line_idx;
        x_n      = x;
        y_n      = y;
        odd_n    = odd;
        sel_n    = sel;
        done_n   = 1'b0;
        line_end = (cnt == CW'(LINE_TICKS - 1));
        case (state)
            S_VSYNC: seg_last = LW'(VSYNC_LINES - 1);
            S_VBP:   seg_last = LW'(V_BP - 1);
            default: seg_last = LW'(V_FP - 1);
        endcase
        seg_end = line_end && (line_idx == seg_last);

        // VSYNC, VBP and VFP share one line/tick counter pair; only the
        // exit taken at the end of the segment differs.
        if (state == S_VSYNC || state == S_VBP || state == S_VFP) begin
            if (line_end) begin
                cnt_n  = '0;
                line_n = seg_end ? '0 : line_idx + LW'(1);
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_VSYNC;
                    cnt_n   = '0;
                    line_n  = '0;
                    sel_n   = pattern_sel;
                end
            end
            S_VSYNC: if (seg_end) state_n = S_VBP;
            S_VBP: begin
                if (seg_end) begin
                    state_n = S_ACTIVE;
                    x_n     = '0;
                    y_n     = '0;
                    odd_n   = 1'b0;
                end
            end
            S_ACTIVE: begin
                odd_n = ~odd;
                if (odd) begin
                    if (x == XW'(H_ACTIVE - 1)) begin
                        state_n = S_HBLANK;
                        cnt_n   = '0;
                    end else begin
                        x_n = x + XW'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt == CW'(H_BLANK - 1)) begin
                    x_n = '0;
                    if (y == YW'(V_ACTIVE - 1)) begin
                        state_n = S_VFP;
                        cnt_n   = '0;
                        line_n  = '0;
                        y_n     = '0;
                    end else begin
                        state_n = S_ACTIVE;
                        y_n     = y + YW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_VFP: begin
                if (seg_end) begin
                    done_n = 1'b1;
                    if (enable) begin
                        state_n = S_VSYNC;
                        sel_n   = pattern_sel;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Outputs are derived from the next state so they change on the same tick.
        href_n  = (state_n == S_ACTIVE);
        vsync_n = (state_n == S_VSYNC);
        data_n  = href_n ? (odd_n ? rgb[7:0] : rgb[15:8]) : '0;
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            line_idx <= '0;
            x        <= '0;
            y        <= '0;
            odd      <= 1'b0;
            sel      <= '0;
        end else if (tick) begin
            state    <= state_n;
            cnt      <= cnt_n;
            line_idx <= line_n;
            x        <= x_n;
            y        <= y_n;
            odd      <= odd_n;
            sel      <= sel_n;
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            ph         <= '0;
            PCLK_OV    <= 1'b0;
            HREF_OV    <= 1'b0;
            VSYNC_OV   <= 1'b0;
            OV_Data_in <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            ph         <= ph_n;
            PCLK_OV    <= (ph_n >= PW'(PCLK_DIV / 2));
            frame_done <= tick && done_n;
            if (tick) begin
                HREF_OV    <= href_n;
                VSYNC_OV   <= vsync_n;
                OV_Data_in <= data_n;
                if (done_n) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov_sensor_emulator.sv
// Directed bench for ov_sensor_emulator on a small 8x4 geometry
// (20-tick lines, 140-tick frames, PCLK = clk/4).
module tb_ov_sensor_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       PCLK_OV, HREF_OV, VSYNC_OV, frame_done;
    logic [7:0] OV_Data_in, frame_cnt;

    int checks = 0;
    int errors = 0;

    ov_sensor_emulator #(
        .H_ACTIVE   (8),
        .V_ACTIVE   (4),
        .H_BLANK    (4),
        .VSYNC_LINES(1),
        .V_BP       (1),
        .V_FP       (1),
        .PCLK_DIV   (4)
    ) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .PCLK_OV    (PCLK_OV),
        .HREF_OV    (HREF_OV),
        .VSYNC_OV   (VSYNC_OV),
        .OV_Data_in (OV_Data_in),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Expected phase: counts 0..3 from reset release.
    int ph_model = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) ph_model <= 0;
        else     ph_model <= (ph_model + 1) % 4;
    end

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc[$];
    logic prev_done = 1'b0;
    logic double_pulse = 1'b0;
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_done <= frame_done;
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (frame_done && prev_done) double_pulse <= 1'b1;
    end

    logic [7:0] BARS  [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                               8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    logic [7:0] SOLID [16] = '{16{8'hFF}};
    logic [7:0] RAMP2 [16] = '{8'h00, 8'h42, 8'h08, 8'h43, 8'h10, 8'h40, 8'h18, 8'h41,
                               8'h20, 8'h46, 8'h28, 8'h47, 8'h30, 8'h44, 8'h38, 8'h45};

    logic       s_href, s_vsync, prev_vs = 1'b0;
    logic [7:0] s_data, s_fc;
    logic       f_href [140];
    logic       f_vs   [140];
    logic [7:0] f_data [140];
    logic [7:0] f_fc0;
    int         wait_ticks;

    // Sample outputs 1 time unit after each PCLK rising edge.
    task automatic get_tick();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = PCLK_OV;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (PCLK_OV && !prev) begin
                found = 1'b1;
                break;
            end
            prev = PCLK_OV;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL pclk_timeout: no PCLK rise within 8 clk, got none, required one");
        end
        prev_vs = s_vsync;
        s_href  = HREF_OV;
        s_vsync = VSYNC_OV;
        s_data  = OV_Data_in;
        s_fc    = frame_cnt;
    endtask

    task automatic capture_frame(input int chg_at, input logic [1:0] chg_sel, input logic chg_en);
        bit got;
        got        = 1'b0;
        wait_ticks = 0;
        for (int i = 0; i < 300; i++) begin
            get_tick();
            wait_ticks++;
            if (s_vsync && !prev_vs) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL vsync_timeout: no VSYNC rise in 300 ticks, got none, required one");
        end
        for (int t = 0; t < 140; t++) begin
            if (t > 0) get_tick();
            f_href[t] = s_href;
            f_vs[t]   = s_vsync;
            f_data[t] = s_data;
            if (t == 0) f_fc0 = s_fc;
            if (t == chg_at) begin
                pattern_sel = chg_sel;
                enable      = chg_en;
            end
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL frame_done_timeout: got no pulse within 16 clk, required one");
        end
    endtask

    task automatic check_timing(input string nm);
        int pulses;
        pulses = 0;
        for (int t = 0; t < 140; t++) begin
            logic ev, eh;
            ev = (t < 20);
            eh = (t >= 40) && (t < 120) && (((t - 40) % 20) < 16);
            checks++;
            if (f_vs[t] !== ev) begin
                errors++;
                $display("FAIL %s_vsync t=%0d: got %b required %b", nm, t, f_vs[t], ev);
            end
            checks++;
            if (f_href[t] !== eh) begin
                errors++;
                $display("FAIL %s_href t=%0d: got %b required %b", nm, t, f_href[t], eh);
            end
            if (!eh) begin
                checks++;
                if (f_data[t] !== 8'h00) begin
                    errors++;
                    $display("FAIL %s_blank_data t=%0d: got %02h required 00", nm, t, f_data[t]);
                end
            end
            if (t > 0 && f_href[t] && !f_href[t-1]) pulses++;
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL %s_href_pulses: got %0d required 4", nm, pulses);
        end
    endtask

    task automatic check_line(input string nm, input int l, input logic [7:0] exp_b [16]);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (f_data[40 + 20*l + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL %s line%0d byte%0d: got %02h required %02h",
                         nm, l, i, f_data[40 + 20*l + i], exp_b[i]);
            end
        end
    endtask

    task automatic check_fc0(input string nm, input logic [7:0] exp_fc);
        checks++;
        if (f_fc0 !== exp_fc) begin
            errors++;
            $display("FAIL %s_frame_cnt: got %0d required %0d", nm, f_fc0, exp_fc);
        end
    endtask

    task automatic test_reset();
        int highs;
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({PCLK_OV, HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b %02h %02h required all zero",
                     PCLK_OV, HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt);
        end
        rst   = 1'b0;
        highs = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (PCLK_OV) highs++;
            checks++;
            if (PCLK_OV !== (ph_model >= 2)) begin
                errors++;
                $display("FAIL idle_pclk cyc=%0d: got %b required %b", k, PCLK_OV, ph_model >= 2);
            end
            checks++;
            if ({HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt} !== 19'h0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d: got %b%b%b %02h %02h required all zero",
                         k, HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt);
            end
        end
        checks++;
        if (highs != 500) begin
            errors++;
            $display("FAIL idle_pclk_duty: got %0d high cycles required 500", highs);
        end
    endtask

    task automatic test_bars();
        get_tick();
        pattern_sel = 2'd0;
        enable      = 1'b1;
        capture_frame(-1, 2'd0, 1'b1);
        checks++;
        if (wait_ticks != 1) begin
            errors++;
            $display("FAIL bars_start_latency: got %0d ticks required 1", wait_ticks);
        end
        check_fc0("bars", 8'd0);
        check_timing("bars");
        for (int l = 0; l < 4; l++) check_line("bars", l, BARS);
    endtask

    task automatic test_continuous();
        capture_frame(-1, 2'd0, 1'b1);
        check_fc0("cont2", 8'd1);
        check_line("cont2", 3, BARS);
        capture_frame(-1, 2'd0, 1'b1);
        check_fc0("cont3", 8'd2);
        check_timing("cont3");
        wait_done();
        checks++;
        if (frame_cnt !== 8'd3) begin
            errors++;
            $display("FAIL cont_frame_cnt: got %0d required 3", frame_cnt);
        end
        @(negedge clk);
        checks++;
        if (done_cyc.size() != 3) begin
            errors++;
            $display("FAIL cont_done_count: got %0d required 3", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] != 560 || done_cyc[2] - done_cyc[1] != 560) begin
                errors++;
                $display("FAIL cont_done_period: got %0d,%0d required 560,560",
                         done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
        checks++;
        if (double_pulse !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got multi-cycle pulse, required single cycle");
        end
    endtask

    task automatic test_sel_change();
        capture_frame(60, 2'd3, 1'b1);
        check_fc0("selchg4", 8'd3);
        for (int l = 0; l < 4; l++) check_line("selchg4", l, BARS);
        capture_frame(-1, 2'd3, 1'b1);
        check_fc0("selchg5", 8'd4);
        check_timing("solid");
        for (int l = 0; l < 4; l++) check_line("solid", l, SOLID);
    endtask

    task automatic test_enable_drop();
        int dc;
        capture_frame(85, 2'd3, 1'b0);
        check_fc0("endrop", 8'd5);
        check_timing("endrop");
        check_line("endrop", 3, SOLID);
        wait_done();
        checks++;
        if (frame_cnt !== 8'd6) begin
            errors++;
            $display("FAIL endrop_frame_cnt: got %0d required 6", frame_cnt);
        end
        @(negedge clk);
        dc = done_cnt;
        for (int t = 0; t < 160; t++) begin
            get_tick();
            checks++;
            if (s_vsync !== 1'b0 || s_href !== 1'b0 || s_data !== 8'h00) begin
                errors++;
                $display("FAIL endrop_idle t=%0d: got vs=%b href=%b data=%02h required 0 0 00",
                         t, s_vsync, s_href, s_data);
            end
        end
        checks++;
        if (done_cnt != dc || frame_cnt !== 8'd6) begin
            errors++;
            $display("FAIL endrop_idle_count: got done=%0d cnt=%0d required done=%0d cnt=6",
                     done_cnt, frame_cnt, dc);
        end
    endtask

    task automatic test_reset_mid();
        int  dc;
        bit  got;
        pattern_sel = 2'd1;
        enable      = 1'b1;
        capture_frame(50, 2'd2, 1'b1);
        checks++;
        if (wait_ticks != 1) begin
            errors++;
            $display("FAIL ramp_start_latency: got %0d ticks required 1", wait_ticks);
        end
        check_fc0("ramp", 8'd6);
        check_line("ramp", 2, RAMP2);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            get_tick();
            if (s_href) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL checker_href_timeout: got no HREF in 60 ticks, required one");
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) get_tick();
            checks++;
            if (s_href !== 1'b1 || s_data !== 8'h00) begin
                errors++;
                $display("FAIL checker byte%0d: got href=%b data=%02h required 1 00", i, s_href, s_data);
            end
        end
        dc  = done_cnt;
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({PCLK_OV, HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b%b%b%b %02h %02h required all zero",
                     PCLK_OV, HREF_OV, VSYNC_OV, frame_done, OV_Data_in, frame_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (PCLK_OV !== (ph_model >= 2)) begin
                errors++;
                $display("FAIL midreset_pclk cyc=%0d: got %b required %b", k, PCLK_OV, ph_model >= 2);
            end
        end
        get_tick();
        checks++;
        if (s_vsync !== 1'b0 || done_cnt != dc || s_fc !== 8'd0) begin
            errors++;
            $display("FAIL midreset_idle: got vs=%b done=%0d cnt=%0d required 0 %0d 0",
                     s_vsync, done_cnt, s_fc, dc);
        end
        pattern_sel = 2'd0;
        enable      = 1'b1;
        capture_frame(-1, 2'd0, 1'b1);
        checks++;
        if (wait_ticks != 1) begin
            errors++;
            $display("FAIL midreset_start_latency: got %0d ticks required 1", wait_ticks);
        end
        check_fc0("midreset", 8'd0);
        check_timing("midreset");
        check_line("midreset", 0, BARS);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        test_reset();
        test_bars();
        test_continuous();
        test_sel_change();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
